// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel stream in / packed 3x3 window out bundle
interface conv_window_gen_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0]   pixel_in;
  logic                   pixel_valid;
  logic [9*DataWidth-1:0] window_out;
  logic                   window_valid;
  logic                   frame_done;

  modport master (
    output pixel_in,
    output pixel_valid,
    input  window_out,
    input  window_valid,
    input  frame_done
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    output window_out,
    output window_valid,
    output frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 sliding-window generator, valid convolution
module conv_window_gen #(
  parameter int DataWidth = 32,
  parameter int ImgWidth  = 8,
  parameter int ImgHeight = 8
) (
  input logic              Clk,
  input logic              Rst,
  conv_window_gen_if.slave px
);
  localparam int ColW = $clog2(ImgWidth);
  localparam int RowW = $clog2(ImgHeight);
  localparam logic [ColW-1:0] ColLast = ColW'(ImgWidth - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ImgHeight - 1);

  logic [ColW-1:0]        col;
  logic [RowW-1:0]        row;
  logic [DataWidth-1:0]   lb0 [ImgWidth];
  logic [DataWidth-1:0]   lb1 [ImgWidth];
  // Two newest window columns; the oldest column only ever lives in window_out.
  logic [DataWidth-1:0]   w [3][2];
  logic [DataWidth-1:0]   tap1;
  logic [DataWidth-1:0]   tap2;
  logic                   accept;
  logic                   emit;
  logic                   last_px;
  logic [9*DataWidth-1:0] next_window;

  assign accept  = px.pixel_valid && !Rst;
  assign tap1    = lb0[col];
  assign tap2    = lb1[col];
  assign emit    = accept && (row >= RowW'(2)) && (col >= ColW'(2));
  assign last_px = (row == RowLast) && (col == ColLast);

  // Element k = 3r+c sits at slot (9-k), top-left in the MSBs.
  always_comb begin
    next_window = '0;
    for (int r = 0; r < 3; r++) begin
      next_window[(9-3*r)*DataWidth-1 -: DataWidth] = w[r][0];
      next_window[(8-3*r)*DataWidth-1 -: DataWidth] = w[r][1];
    end
    next_window[7*DataWidth-1 -: DataWidth] = tap2;
    next_window[4*DataWidth-1 -: DataWidth] = tap1;
    next_window[DataWidth-1:0]              = px.pixel_in;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col             <= '0;
      row             <= '0;
      px.window_out   <= '0;
      px.window_valid <= 1'b0;
      px.frame_done   <= 1'b0;
    end else begin
      px.window_valid <= emit;
      px.frame_done   <= emit && last_px;
      if (emit) begin
        px.window_out <= next_window;
      end
      if (accept) begin
        if (col == ColLast) begin
          col <= '0;
          row <= (row == RowLast) ? '0 : row + RowW'(1);
        end else begin
          col <= col + ColW'(1);
        end
      end
    end
  end

  // Storage needs no clearing: the row/col guards never emit stale entries.
  always_ff @(posedge Clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= px.pixel_in;
      w[0][0]  <= w[0][1];
      w[1][0]  <= w[1][1];
      w[2][0]  <= w[2][1];
      w[0][1]  <= tap2;
      w[1][1]  <= tap1;
      w[2][1]  <= px.pixel_in;
    end
  end
endmodule
